// File: rtl/pipe_regfile.sv
// Register file with combinational read ports, optional write-to-read forwarding
// and a per-register pending-write scoreboard for a pipelined core.
module pipe_regfile #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 3,
   parameter int INIT_STEP = 10,
   parameter int BYPASS    = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_W-1:0]      readreg1,
   input  logic [ADDR_W-1:0]      readreg2,
   output logic [DATA_W-1:0]      readdata1,
   output logic [DATA_W-1:0]      readdata2,
   input  logic                   RegWrite,
   input  logic [ADDR_W-1:0]      writereg,
   input  logic [DATA_W-1:0]      writedata,
   input  logic                   issue_en,
   input  logic [ADDR_W-1:0]      issue_reg,
   input  logic                   flush,
   output logic                   busy1,
   output logic                   busy2,
   output logic [2**ADDR_W-1:0]   busy_vec
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0]            regs [DEPTH];
   logic [DEPTH-1:0]             busy_reg;
   logic [DEPTH-1:0]             busy_next;
   logic                         wr_en;
   logic [1:0][ADDR_W-1:0]       raddr;
   logic [1:0][DATA_W-1:0]       rdata;
   logic [1:0]                   rbusy;

   assign wr_en = RegWrite && (writereg != '0);

   // Entry 0 is reset to zero and never written, so it stays zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= DATA_W'(i * INIT_STEP);
         end
         busy_reg <= '0;
      end else begin
         if (wr_en) begin
            regs[writereg] <= writedata;
         end
         busy_reg <= busy_next;
      end
   end

   // Flush beats everything; a new issue beats the writeback clear of an older producer.
   assign busy_next[0] = 1'b0;
   for (genvar gi = 1; gi < DEPTH; gi++) begin : g_busy
      assign busy_next[gi] = flush                                          ? 1'b0 :
                             (issue_en && (issue_reg == ADDR_W'(gi)))       ? 1'b1 :
                             (wr_en && (writereg == ADDR_W'(gi)))           ? 1'b0 :
                                                                              busy_reg[gi];
   end

   assign raddr = {readreg2, readreg1};

   // Forwarding is suppressed during reset so reads show reset contents.
   for (genvar gi = 0; gi < 2; gi++) begin : g_read
      logic fwd;
      assign fwd = (BYPASS != 0) && !rst && wr_en && (writereg == raddr[gi]);
      assign rdata[gi] = (raddr[gi] == '0) ? '0 :
                         fwd               ? writedata :
                                             regs[raddr[gi]];
      assign rbusy[gi] = busy_reg[raddr[gi]] & ~fwd;
   end

   assign readdata1 = rdata[0];
   assign readdata2 = rdata[1];
   assign busy1     = rbusy[0];
   assign busy2     = rbusy[1];
   assign busy_vec  = busy_reg;

endmodule

// File: doc/pipe_regfile.md
PIPE_REGFILE -- requirements
Module: pipe_regfile

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 3, address width; depth = 2**ADDR_W registers.
REQ-003 SHALL provide parameter INIT_STEP, default 10, reset value multiplier; reg[i] resets to i*INIT_STEP.
REQ-004 SHALL provide parameter BYPASS, default 1, enabling write-to-read forwarding when set to 1.
REQ-005 SHALL provide port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL provide ports readreg1 and readreg2, input, ADDR_W each, read addresses.
REQ-008 SHALL provide ports readdata1 and readdata2, output, DATA_W each, read data.
REQ-009 SHALL provide port RegWrite, input, 1, writeback enable.
REQ-010 SHALL provide port writereg, input, ADDR_W, writeback address.
REQ-011 SHALL provide port writedata, input, DATA_W, writeback data.
REQ-012 SHALL provide port issue_en, input, 1, marks destination issue_reg as pending.
REQ-013 SHALL provide port issue_reg, input, ADDR_W, destination of the issuing instruction.
REQ-014 SHALL provide port flush, input, 1, clears all pending marks.
REQ-015 SHALL provide ports busy1 and busy2, output, 1 each, pending status of readreg1 and readreg2.
REQ-016 SHALL provide port busy_vec, output, 2**ADDR_W, raw scoreboard state, bit i for reg i.

Function
REQ-017 SHALL write writedata to reg[writereg] on the rising clk edge when RegWrite=1 and writereg!=0.
REQ-018 SHALL hold reg[0] at 0 permanently; writes to address 0 are ignored; reads of address 0 return 0.
REQ-019 SHALL produce readdata1 and readdata2 combinationally, with zero latency, from the current array contents.
REQ-020 SHALL, when BYPASS=1, RegWrite=1 and writereg==readregN!=0, drive readdataN = writedata in the same cycle.
REQ-021 SHALL, when BYPASS=0, return pre-write contents in the write cycle and the new value from the next cycle.
REQ-022 SHALL set busy_vec[issue_reg] on the clk edge when issue_en=1 and issue_reg!=0.
REQ-023 SHALL clear busy_vec[writereg] on the clk edge when RegWrite=1 and writereg!=0.
REQ-024 SHALL let set win on a same-address set and clear in one cycle, so the bit stays 1 for the newer producer.
REQ-025 SHALL let flush=1 clear every busy bit on the clk edge, overriding same-cycle issue_en and RegWrite clears; the register write itself still occurs.
REQ-026 SHALL hold busy_vec[0] at 0 always.
REQ-027 SHALL drive busyN = busy_vec[readregN] & ~(BYPASS & RegWrite & writereg==readregN), so a value being forwarded is not reported busy.
REQ-028 SHALL truncate i*INIT_STEP to DATA_W bits (modulo 2**DATA_W).
REQ-029 SHALL allow both read ports to address the same register, each receiving identical data and busy status.

Reset
REQ-030 SHALL, while rst=1, immediately set reg[i]=i*INIT_STEP (reg[0]=0) and clear busy_vec, independent of clk.
REQ-031 SHALL, at reset, present readdataN = reset value of readregN, busy1=busy2=0 and busy_vec=0.
REQ-032 SHALL ignore RegWrite, issue_en and flush while rst=1; asserting rst mid-operation discards pending writes and marks.
REQ-033 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Verification
REQ-034 SHALL cover the reset check: assert rst, then read addresses 0..7 -> readdata 0,10,20,...,70 and busy_vec=8'h00.
REQ-035 SHALL cover the bypass write: RegWrite=1, writereg=3, writedata=16'h1234, readreg1=3 in the same cycle -> readdata1=16'h1234 with BYPASS=1, or 30 with BYPASS=0 and 16'h1234 the next cycle.
REQ-036 SHALL cover the register-0 write: RegWrite=1, writereg=0, writedata=16'hFFFF -> readdata of reg 0 remains 0, and busy_vec[0]=0 even with issue_reg=0.
REQ-037 SHALL cover issue then writeback: issue_en with issue_reg=5 -> busy1=1 for readreg1=5 the next cycle; later writeback to reg 5 -> busy1=0 in that cycle (BYPASS=1), and busy_vec[5]=0 after the edge.
REQ-038 SHALL cover the set/clear race and flush: issue_en and RegWrite both on reg 2 -> busy_vec[2]=1; flush with issue_en on reg 4 -> busy_vec=0.
REQ-039 SHALL cover asynchronous reset mid-run: rst pulsed between clk edges after writing reg 6 = 16'h00AA -> reg 6 reads 60 immediately and busy_vec=0.
